// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped peripherals: word RAM, free-running timer,
// 4-entry output FIFO with sticky overflow, status register and LED register.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  led
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] ram_q  [RAM_WORDS];
  logic [31:0] fifo_q [FIFO_DEPTH];

  logic [31:0] timer_q, timer_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  led_q, led_d;

  logic        is_ram, is_mmio;
  logic [15:0] off;
  logic        wr_ram, wr_timer, wr_fifo, wr_status, wr_led;
  logic        full, empty, pop, push_ok, push_drop;
  logic [AW-1:0] ram_idx;

  assign is_ram  = ~addr[31];
  assign is_mmio = (addr[31:16] == 16'hFFFF);
  assign off     = addr[15:0];
  assign ram_idx = addr[2 +: AW];

  assign wr_ram    = memwrite & is_ram;
  assign wr_timer  = memwrite & is_mmio & (off == 16'h0000);
  assign wr_fifo   = memwrite & is_mmio & (off == 16'h0004);
  assign wr_status = memwrite & is_mmio & (off == 16'h0008);
  assign wr_led    = memwrite & is_mmio & (off == 16'h000C);

  assign empty     = (count_q == 3'd0);
  assign full      = (count_q == 3'(FIFO_DEPTH));
  assign pop       = ~empty & out_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok   = wr_fifo & (~full | pop);
  assign push_drop = wr_fifo & full & ~pop;

  always_comb begin
    timer_d  = timer_q + 32'd1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {2'b00, push_ok} - {2'b00, pop};
    ovf_d    = ovf_q;
    led_d    = led_q;
    if (wr_timer) timer_d = writedata;
    if (push_ok) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    if (push_drop) ovf_d = 1'b1;
    else if (wr_status && writedata[2]) ovf_d = 1'b0;
    if (wr_led) led_d = writedata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      led_q    <= '0;
    end else begin
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      led_q    <= led_d;
    end
  end

  // Storage arrays carry no reset; FIFO entries are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (wr_ram) ram_q[ram_idx] <= writedata;
    if (push_ok) fifo_q[wr_ptr_q] <= writedata;
  end

  always_comb begin
    readdata = 32'h0;
    if (is_ram) begin
      readdata = ram_q[ram_idx];
    end else if (is_mmio) begin
      case (off)
        16'h0000: readdata = timer_q;
        16'h0008: readdata = {26'b0, count_q, ovf_q, full, empty};
        16'h000C: readdata = {24'b0, led_q};
        default:  readdata = 32'h0;
      endcase
    end
  end

  assign out_data  = fifo_q[rd_ptr_q];
  assign out_valid = ~empty;
  assign led       = led_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus a randomized mix
// checked against a queue/array reference model.
module tb_dmem_mmio;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  led;

  int nerr = 0;
  int ncheck = 0;

  logic [31:0] m_timer;
  logic [31:0] m_q[$];
  logic        m_ovf;
  logic [7:0]  m_led;
  logic [31:0] m_ram [64];
  bit          m_ram_ok [64];

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
    .writedata(writedata), .readdata(readdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .led(led)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    int n;
    n = m_q.size();
    if (!a[31]) return m_ram[a[7:2]];
    if (a[31:16] == 16'hFFFF) begin
      case (a[15:0])
        16'h0000: return m_timer;
        16'h0008: return {26'b0, 3'(n), m_ovf, n == 4, n == 0};
        16'h000C: return {24'b0, m_led};
        default:  return 32'h0;
      endcase
    end
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_timer = 0;
    m_q.delete();
    m_ovf = 0;
    m_led = 0;
  endtask

  // One clock edge with the given inputs; the model advances by the same edge.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic rdy);
    logic mm;
    logic [31:0] tmp;
    memwrite = we; addr = a; writedata = d; out_ready = rdy;
    mm = (a[31:16] == 16'hFFFF);
    $display("txn t=%0t we=%0b addr=%h wd=%h rdy=%0b", $time, we, a, d, rdy);
    if (m_q.size() != 0 && rdy) tmp = m_q.pop_front();
    if (we && mm && a[15:0] == 16'h0000) m_timer = d;
    else m_timer = m_timer + 1;
    if (we && mm && a[15:0] == 16'h0008 && d[2]) m_ovf = 0;
    if (we && mm && a[15:0] == 16'h0004) begin
      if (m_q.size() < 4) m_q.push_back(d);
      else m_ovf = 1;
    end
    if (we && mm && a[15:0] == 16'h000C) m_led = d[7:0];
    if (we && !a[31]) begin
      m_ram[a[7:2]] = d;
      m_ram_ok[a[7:2]] = 1;
    end
    @(posedge clk); #1;
    memwrite = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    model_reset();
    addr = 32'hFFFF0000; #1;
    ncheck++; if (readdata !== 32'h0) begin nerr++; $display("FAIL reset_timer got=%h exp=%h", readdata, 32'h0); end
    ncheck++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    ncheck++; if (led !== 8'h00) begin nerr++; $display("FAIL reset_led got=%h exp=00", led); end
    addr = 32'hFFFF0008; #1;
    ncheck++; if (readdata !== 32'h1) begin nerr++; $display("FAIL reset_status got=%h exp=%h", readdata, 32'h1); end
    reset = 0;
    addr = 32'hFFFF0000; #1;
    ncheck++; if (readdata !== 32'h0) begin nerr++; $display("FAIL timer_before_edge got=%h exp=0", readdata); end
    cycle(0, 32'hFFFF0000, 0, 0);
    ncheck++; if (readdata !== 32'h1) begin nerr++; $display("FAIL timer_first_inc got=%h exp=1", readdata); end
  endtask

  task automatic test_ram();
    cycle(1, 32'h00000010, 32'hDEADBEEF, 0);
    addr = 32'h00000010; #1;
    ncheck++; if (readdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL ram_load got=%h exp=DEADBEEF", readdata); end
    addr = 32'h00000110; #1;
    ncheck++; if (readdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL ram_alias got=%h exp=DEADBEEF", readdata); end
    addr = 32'h00000013; #1;
    ncheck++; if (readdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL ram_byteoff got=%h exp=DEADBEEF", readdata); end
  endtask

  task automatic test_timer();
    cycle(1, 32'hFFFF0000, 32'hFFFFFFFE, 0);
    ncheck++; if (readdata !== 32'hFFFFFFFE) begin nerr++; $display("FAIL timer_load got=%h exp=FFFFFFFE", readdata); end
    cycle(0, 32'hFFFF0000, 0, 0);
    ncheck++; if (readdata !== 32'hFFFFFFFF) begin nerr++; $display("FAIL timer_edge1 got=%h exp=FFFFFFFF", readdata); end
    cycle(0, 32'hFFFF0000, 0, 0);
    ncheck++; if (readdata !== 32'h0) begin nerr++; $display("FAIL timer_wrap got=%h exp=0", readdata); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] w;
    for (int i = 1; i <= 5; i++) begin
      w = i;
      cycle(1, 32'hFFFF0004, w, 0);
      if (i == 1) begin
        ncheck++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin nerr++; $display("FAIL fifo_first got=%b/%h exp=1/1", out_valid, out_data); end
      end
    end
    addr = 32'hFFFF0008; #1;
    ncheck++; if (readdata !== 32'h26) begin nerr++; $display("FAIL status_full got=%h exp=26", readdata); end
    addr = 32'hFFFF0004; #1;
    ncheck++; if (readdata !== 32'h0) begin nerr++; $display("FAIL fifo_data_read got=%h exp=0", readdata); end
    for (int i = 1; i <= 4; i++) begin
      w = i;
      ncheck++; if (out_valid !== 1'b1 || out_data !== w) begin nerr++; $display("FAIL drain_%0d got=%b/%h exp=1/%h", i, out_valid, out_data, w); end
      cycle(0, 32'hFFFF0008, 0, 1);
    end
    ncheck++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL drained_valid got=%b exp=0", out_valid); end
    ncheck++; if (readdata !== 32'h05) begin nerr++; $display("FAIL status_empty_ovf got=%h exp=05", readdata); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] w;
    for (int i = 5; i <= 8; i++) begin
      w = i;
      cycle(1, 32'hFFFF0004, w, 0);
    end
    cycle(1, 32'hFFFF0004, 32'd9, 1);
    addr = 32'hFFFF0008; #1;
    ncheck++; if (readdata !== 32'h26) begin nerr++; $display("FAIL full_pushpop_status got=%h exp=26", readdata); end
    for (int i = 6; i <= 9; i++) begin
      w = i;
      ncheck++; if (out_data !== w) begin nerr++; $display("FAIL pushpop_order_%0d got=%h exp=%h", i, out_data, w); end
      cycle(0, 32'h0, 0, 1);
    end
    cycle(1, 32'hFFFF0008, 32'h4, 0);
    ncheck++; if (readdata !== 32'h01) begin nerr++; $display("FAIL ovf_clear got=%h exp=01", readdata); end
  endtask

  task automatic test_led_unmapped();
    cycle(1, 32'hFFFF000C, 32'h1A5, 0);
    ncheck++; if (led !== 8'hA5) begin nerr++; $display("FAIL led_port got=%h exp=A5", led); end
    ncheck++; if (readdata !== 32'hA5) begin nerr++; $display("FAIL led_read got=%h exp=A5", readdata); end
    cycle(1, 32'h80000000, 32'h12345678, 0);
    ncheck++; if (readdata !== 32'h0) begin nerr++; $display("FAIL unmapped_read got=%h exp=0", readdata); end
    cycle(1, 32'hFFFF0010, 32'h12345678, 0);
    ncheck++; if (readdata !== 32'h0) begin nerr++; $display("FAIL mmio_hole_read got=%h exp=0", readdata); end
    ncheck++; if (led !== 8'hA5) begin nerr++; $display("FAIL led_kept got=%h exp=A5", led); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, tmp, e;
    logic we, rdy;
    for (int n = 0; n < 400; n++) begin
      tmp = $urandom;
      d = $urandom;
      case ($urandom_range(0, 5))
        0, 1: a = {1'b0, tmp[30:0]};
        2, 3: a = 32'hFFFF0004;
        4:    a = 32'hFFFF0000 | (32'd4 * 32'($urandom_range(0, 4)));
        default: a = 32'h80000000 | (tmp & 32'h3FFFFFFF);
      endcase
      if (a == 32'hFFFF0008) d = d & 32'hFFFFFFFB | (32'($urandom_range(0, 1)) << 2);
      we = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 2) == 0);
      addr = a; #1;
      e = exp_read(a);
      if (a[31] || m_ram_ok[a[7:2]]) begin
        ncheck++; if (readdata !== e) begin nerr++; $display("FAIL rnd_read addr=%h got=%h exp=%h", a, readdata, e); end
      end
      ncheck++; if (out_valid !== (m_q.size() != 0)) begin nerr++; $display("FAIL rnd_valid got=%b exp=%0d", out_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        ncheck++; if (out_data !== m_q[0]) begin nerr++; $display("FAIL rnd_head got=%h exp=%h", out_data, m_q[0]); end
      end
      ncheck++; if (led !== m_led) begin nerr++; $display("FAIL rnd_led got=%h exp=%h", led, m_led); end
      cycle(we, a, d, rdy);
    end
    addr = 32'hFFFF0008; #1;
    e = exp_read(addr);
    ncheck++; if (readdata !== e) begin nerr++; $display("FAIL rnd_status got=%h exp=%h", readdata, e); end
  endtask

  task automatic test_async_reset();
    cycle(1, 32'h00000010, 32'h13572468, 0);
    cycle(1, 32'hFFFF000C, 32'h3C, 0);
    cycle(1, 32'hFFFF0004, 32'hAA, 0);
    cycle(1, 32'hFFFF0004, 32'hBB, 0);
    ncheck++; if (out_valid !== 1'b1 || led !== 8'h3C) begin nerr++; $display("FAIL prereset got=%b/%h exp=1/3C", out_valid, led); end
    addr = 32'hFFFF0000;
    #2 reset = 1;
    #1;
    model_reset();
    ncheck++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL async_valid got=%b exp=0", out_valid); end
    ncheck++; if (led !== 8'h00) begin nerr++; $display("FAIL async_led got=%h exp=00", led); end
    ncheck++; if (readdata !== 32'h0) begin nerr++; $display("FAIL async_timer got=%h exp=0", readdata); end
    memwrite = 1; addr = 32'hFFFF000C; writedata = 32'hFF;
    @(posedge clk); #1;
    memwrite = 0; reset = 0; #1;
    ncheck++; if (led !== 8'h00) begin nerr++; $display("FAIL reset_edge_store got=%h exp=00", led); end
    addr = 32'hFFFF0000; #1;
    ncheck++; if (readdata !== 32'h0) begin nerr++; $display("FAIL post_reset_timer got=%h exp=0", readdata); end
    addr = 32'h00000010; #1;
    ncheck++; if (readdata !== 32'h13572468) begin nerr++; $display("FAIL ram_retained got=%h exp=13572468", readdata); end
    cycle(0, 32'hFFFF0000, 0, 0);
    ncheck++; if (readdata !== 32'h1) begin nerr++; $display("FAIL post_reset_inc got=%h exp=1", readdata); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      m_ram[i] = 0;
      m_ram_ok[i] = 0;
    end
    model_reset();
    test_reset();
    test_ram();
    test_timer();
    test_fifo_overflow();
    test_full_push_pop();
    test_led_unmapped();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", nerr, ncheck);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
